// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader
//
// Programming-side front end of the configuration scan chain. Host words
// arrive on a valid/ready stream. They are serialised LSB first onto the
// daisy-chained prog_in/prog_en inputs of the programmable muxes and
// connection boxes. Exactly CHAIN_LEN bits are driven per load. The unused
// upper bits of the final word are dropped. Everything runs on prog_clk,
// which is also the chain's shift clock.
//
// Optional feature (macro CFG_READBACK_EN):
//   A CRC-16 (poly 0x1021, init 0xFFFF) is accumulated over the driven bits.
//   A VERIFY pass then recirculates the chain for CHAIN_LEN more cycles
//   (chain_data = chain_ret) and computes a second CRC over chain_ret.
//   A CRC mismatch raises the sticky error flag together with done.
//   Without the macro there is no VERIFY state and error is tied to 0.
//
// Ports:
//   prog_clk    in   programming clock, shared with the chain
//   prog_rst    in   synchronous active-high reset
//   start       in   begin a load; only looked at while idle
//   s_data      in   [WORD_W] configuration word, bit 0 shifted first
//   s_valid     in   s_data valid
//   s_ready     out  loader accepts s_data this cycle
//   chain_data  out  serial bit to the first stage's prog_in
//   chain_en    out  chain prog_en; the chain shifts on every edge it is high
//   chain_ret   in   prog_out of the last chain stage
//   busy        out  load (or verify) in progress
//   done        out  one-cycle completion pulse
//   error       out  verify mismatch, sticky until the next start

module cfg_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 80
) (
    input  logic              prog_clk,
    input  logic              prog_rst,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              chain_data,
    output logic              chain_en,
    input  logic              chain_ret,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int BCW    = $clog2(CHAIN_LEN + 1);
    localparam int WBW    = $clog2(WORD_W + 1);
    localparam int WCW    = $clog2(NWORDS + 1);

`ifdef CFG_READBACK_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SHIFT  = 3'd2,
        VERIFY = 3'd3,
        FINISH = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SHIFT  = 3'd2,
        FINISH = 3'd4
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;          // remaining bits of the current word
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;    // bits driven so far, incl. the current one
    logic [WBW-1:0]    wbit_q, wbit_d;          // bits of the current word driven so far
    logic [WCW-1:0]    word_cnt_q, word_cnt_d;  // words accepted in this load
    logic              chain_en_q, chain_en_d;
    logic              chain_data_q, chain_data_d;
    logic              take_word;

`ifdef CFG_READBACK_EN
    logic [15:0] crc_ld_q, crc_ld_d;   // CRC of the bits driven into the chain
    logic [15:0] crc_vf_q, crc_vf_d;   // CRC of the bits coming back out
    logic        error_q, error_d;

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction
`endif

    // The host is offered a slot while fetching, and also in the cycle that
    // drives the last bit of a word, so that back-to-back words stream with
    // no gap. The word counter guarantees nothing beyond NWORDS is consumed.
    always_comb begin
        s_ready = 1'b0;
        if (word_cnt_q < WCW'(NWORDS)) begin
            if (state_q == FETCH) begin
                s_ready = 1'b1;
            end else if (state_q == SHIFT && bit_cnt_q != BCW'(CHAIN_LEN) &&
                         wbit_q == WBW'(WORD_W)) begin
                s_ready = 1'b1;
            end
        end
    end

    assign take_word = s_valid && s_ready;

    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        bit_cnt_d    = bit_cnt_q;
        wbit_d       = wbit_q;
        word_cnt_d   = word_cnt_q;
        chain_en_d   = 1'b0;
        chain_data_d = chain_data_q;
        busy         = 1'b0;
        done         = 1'b0;
`ifdef CFG_READBACK_EN
        crc_ld_d     = crc_ld_q;
        crc_vf_d     = crc_vf_q;
        error_d      = error_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    bit_cnt_d  = '0;
                    wbit_d     = '0;
                    word_cnt_d = '0;
`ifdef CFG_READBACK_EN
                    crc_ld_d   = 16'hFFFF;
                    crc_vf_d   = 16'hFFFF;
                    error_d    = 1'b0;
`endif
                end
            end

            FETCH: begin
                busy = 1'b1;
                if (take_word) begin
                    state_d      = SHIFT;
                    chain_en_d   = 1'b1;
                    chain_data_d = s_data[0];
                    sreg_d       = {1'b0, s_data[WORD_W-1:1]};
                    wbit_d       = WBW'(1);
                    bit_cnt_d    = bit_cnt_q + BCW'(1);
                    word_cnt_d   = word_cnt_q + WCW'(1);
                end
            end

            SHIFT: begin
                busy = 1'b1;
`ifdef CFG_READBACK_EN
                crc_ld_d = crc_step(crc_ld_q, chain_data_q);
`endif
                if (bit_cnt_q == BCW'(CHAIN_LEN)) begin
                    // Last chain bit is on the wire now; leftover word bits are dropped.
`ifdef CFG_READBACK_EN
                    state_d    = VERIFY;
                    chain_en_d = 1'b1;
                    bit_cnt_d  = '0;
`else
                    state_d    = FINISH;
`endif
                end else if (wbit_q == WBW'(WORD_W)) begin
                    if (take_word) begin
                        chain_en_d   = 1'b1;
                        chain_data_d = s_data[0];
                        sreg_d       = {1'b0, s_data[WORD_W-1:1]};
                        wbit_d       = WBW'(1);
                        bit_cnt_d    = bit_cnt_q + BCW'(1);
                        word_cnt_d   = word_cnt_q + WCW'(1);
                    end else begin
                        // Host not ready: park with the chain held.
                        state_d = FETCH;
                    end
                end else begin
                    chain_en_d   = 1'b1;
                    chain_data_d = sreg_q[0];
                    sreg_d       = {1'b0, sreg_q[WORD_W-1:1]};
                    wbit_d       = wbit_q + WBW'(1);
                    bit_cnt_d    = bit_cnt_q + BCW'(1);
                end
            end

`ifdef CFG_READBACK_EN
            VERIFY: begin
                busy     = 1'b1;
                crc_vf_d = crc_step(crc_vf_q, chain_ret);
                // bit_cnt counts completed verify cycles before this one.
                if (bit_cnt_q == BCW'(CHAIN_LEN - 1)) begin
                    state_d = FINISH;
                    error_d = (crc_vf_d != crc_ld_q);
                end else begin
                    chain_en_d = 1'b1;
                    bit_cnt_d  = bit_cnt_q + BCW'(1);
                end
            end
`endif

            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            wbit_q       <= '0;
            word_cnt_q   <= '0;
            chain_en_q   <= 1'b0;
            chain_data_q <= 1'b0;
`ifdef CFG_READBACK_EN
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            wbit_q       <= wbit_d;
            word_cnt_q   <= word_cnt_d;
            chain_en_q   <= chain_en_d;
            chain_data_q <= chain_data_d;
`ifdef CFG_READBACK_EN
            error_q      <= error_d;
`endif
        end
    end

    // Datapath registers: reloaded at every word accept / start, no reset needed.
    always_ff @(posedge prog_clk) begin
        sreg_q <= sreg_d;
`ifdef CFG_READBACK_EN
        crc_ld_q <= crc_ld_d;
        crc_vf_q <= crc_vf_d;
`endif
    end

    assign chain_en = chain_en_q;

`ifdef CFG_READBACK_EN
    // Recirculation must be combinational so the loop stays exactly CHAIN_LEN long.
    assign chain_data = (state_q == VERIFY) ? chain_ret : chain_data_q;
    assign error      = error_q;
`else
    logic unused_chain_ret;
    assign unused_chain_ret = chain_ret;
    assign chain_data       = chain_data_q;
    assign error            = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
module tb_cfg_chain_loader;
    localparam int WORD_W    = 32;
    localparam int CHAIN_LEN = 80;
    localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;
`ifdef CFG_READBACK_EN
    localparam int EN_LOAD = 2 * CHAIN_LEN;
`else
    localparam int EN_LOAD = CHAIN_LEN;
`endif
    localparam int TMO = 2000;

    logic              prog_clk = 1'b0;
    logic              prog_rst, start, s_valid, s_ready;
    logic              chain_data, chain_en, chain_ret, busy, done, error;
    logic [WORD_W-1:0] s_data;

    // Behavioural chain: stage 0 takes prog_in, stage CHAIN_LEN-1 drives prog_out.
    logic [CHAIN_LEN-1:0] chain_m = '0;
    bit                   stuck_en = 1'b0;
    assign chain_ret = stuck_en ? 1'b1 : chain_m[CHAIN_LEN-1];
    always @(posedge prog_clk) if (chain_en) chain_m <= {chain_m[CHAIN_LEN-2:0], chain_data};

    cfg_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
        .prog_clk  (prog_clk),
        .prog_rst  (prog_rst),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .chain_data(chain_data),
        .chain_en  (chain_en),
        .chain_ret (chain_ret),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 prog_clk = ~prog_clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WORD_W-1:0] words [NW];

    // Observation log, sampled on the falling edge.
    int cyc = 0, en_cnt, first_en, last_en, acc_cnt, rdy_late, done_cnt;
    bit busy_at_done, busy_before_done, err_at_done, prev_busy;
    bit en_data [$];

    always @(negedge prog_clk) begin
        cyc++;
        if (chain_en) begin
            en_data.push_back(chain_data);
            en_cnt++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
        end
        if (s_ready && acc_cnt >= NW) rdy_late++;
        if (s_ready && s_valid) acc_cnt++;
        if (done) begin
            done_cnt++;
            busy_at_done     = busy;
            busy_before_done = prev_busy;
            err_at_done      = error;
        end
        prev_busy = busy;
    end

    task automatic clear_mon();
        en_data.delete();
        en_cnt = 0; first_en = -1; last_en = -1;
        acc_cnt = 0; rdy_late = 0; done_cnt = 0;
        busy_at_done = 1'b1; busy_before_done = 1'b0; err_at_done = 1'b0;
    endtask

    // Reference: stream bit k is bit (k mod WORD_W) of word k/WORD_W; readback repeats it.
    function automatic logic exp_bit(input int k);
        logic [WORD_W-1:0] w;
        w = words[(k % CHAIN_LEN) / WORD_W];
        return w[(k % CHAIN_LEN) % WORD_W];
    endfunction

    function automatic int stream_errs();
        int nb = 0;
        for (int k = 0; k < EN_LOAD; k++)
            if (k >= en_data.size() || en_data[k] !== exp_bit(k)) nb++;
        return nb;
    endfunction

    // After a full load, bit k of the stream sits in stage CHAIN_LEN-1-k.
    function automatic int chain_errs();
        int nb = 0;
        for (int k = 0; k < CHAIN_LEN; k++)
            if (chain_m[CHAIN_LEN-1-k] !== exp_bit(k)) nb++;
        return nb;
    endfunction

    function automatic void rand_words();
        for (int i = 0; i < NW; i++) words[i] = $urandom;
    endfunction

    task automatic do_load(input int stall_idx, input int stall_cyc, input bit hold_valid,
                           input bit mid_start, input bit done_start);
        int t;
        @(posedge prog_clk); #1; start = 1'b1;
        @(posedge prog_clk); #1; start = 1'b0;
        for (int i = 0; i < NW; i++) begin
            if (i == stall_idx && stall_cyc > 0) begin
                s_valid = 1'b0;
                t = 0;
                do begin @(negedge prog_clk); #1; t++; end while (!s_ready && t < TMO);
                repeat (stall_cyc) @(posedge prog_clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = words[i];
            t = 0;
            do begin @(negedge prog_clk); #1; t++; end while (!s_ready && t < TMO);
            if (!s_ready) begin
                n_cmp++; n_bad++;
                $display("FAIL load_accept word %0d: s_ready=%0b, want 1", i, s_ready);
                s_valid = 1'b0;
                return;
            end
            @(posedge prog_clk); #1;
            if (i == NW - 1) begin
                s_valid = hold_valid;
                s_data  = $urandom;
            end
            if (mid_start && i == 0) begin
                start = 1'b1;
                @(posedge prog_clk); #1;
                start = 1'b0;
            end
        end
        t = 0;
        do begin @(negedge prog_clk); #1; t++; end while (!done && t < TMO);
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL load_done: done=%0b after %0d cycles, want 1", done, t);
        end
        if (done_start) start = 1'b1;
        @(posedge prog_clk); #1;
        start   = 1'b0;
        s_valid = 1'b0;
        repeat (2) @(posedge prog_clk);
        #1;
    endtask

    task automatic test_reset();
        prog_rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(posedge prog_clk);
        #1;
        n_cmp++; if (s_ready !== 1'b0)    begin n_bad++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
        n_cmp++; if (chain_data !== 1'b0) begin n_bad++; $display("FAIL rst_chain_data: got %b want 0", chain_data); end
        n_cmp++; if (chain_en !== 1'b0)   begin n_bad++; $display("FAIL rst_chain_en: got %b want 0", chain_en); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (error !== 1'b0)      begin n_bad++; $display("FAIL rst_error: got %b want 0", error); end
        prog_rst = 1'b0;
        @(posedge prog_clk); #1;
    endtask

    task automatic test_contiguous();
        words[0] = 32'h89ABCDEF; words[1] = 32'h01234567; words[2] = 32'h0000BEEF;
        clear_mon();
        do_load(-1, 0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (en_cnt !== EN_LOAD) begin n_bad++; $display("FAIL contig_en_cnt: got %0d want %0d", en_cnt, EN_LOAD); end
        n_cmp++; if (last_en - first_en + 1 - en_cnt !== 0) begin n_bad++; $display("FAIL contig_gaps: got %0d want 0", last_en - first_en + 1 - en_cnt); end
        n_cmp++; if (stream_errs() !== 0) begin n_bad++; $display("FAIL contig_stream: %0d wrong bits, want 0", stream_errs()); end
        n_cmp++; if (chain_errs() !== 0)  begin n_bad++; $display("FAIL contig_chain: %0d wrong stages, want 0", chain_errs()); end
        n_cmp++; if (done_cnt !== 1)      begin n_bad++; $display("FAIL contig_done_cnt: got %0d want 1", done_cnt); end
        n_cmp++; if (busy_at_done !== 1'b0 || busy_before_done !== 1'b1) begin
            n_bad++; $display("FAIL contig_busy_fall: busy before/at done %b/%b want 1/0", busy_before_done, busy_at_done); end
        n_cmp++; if (acc_cnt !== NW) begin n_bad++; $display("FAIL contig_accepts: got %0d want %0d", acc_cnt, NW); end
    endtask

    task automatic test_stall();
        words[0] = 32'h89ABCDEF; words[1] = 32'h01234567; words[2] = 32'h0000BEEF;
        clear_mon();
        do_load(1, 5, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (en_cnt !== EN_LOAD) begin n_bad++; $display("FAIL stall_en_cnt: got %0d want %0d", en_cnt, EN_LOAD); end
        n_cmp++; if (last_en - first_en + 1 - en_cnt !== 5) begin n_bad++; $display("FAIL stall_gaps: got %0d want 5", last_en - first_en + 1 - en_cnt); end
        n_cmp++; if (stream_errs() !== 0) begin n_bad++; $display("FAIL stall_stream: %0d wrong bits, want 0", stream_errs()); end
        n_cmp++; if (done_cnt !== 1)      begin n_bad++; $display("FAIL stall_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_upper_discard();
        words[0] = 32'h89ABCDEF; words[1] = 32'h01234567; words[2] = 32'hFFFF0000;
        clear_mon();
        do_load(-1, 0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (en_cnt !== EN_LOAD) begin n_bad++; $display("FAIL discard_en_cnt: got %0d want %0d", en_cnt, EN_LOAD); end
        n_cmp++; if (stream_errs() !== 0) begin n_bad++; $display("FAIL discard_stream: %0d wrong bits, want 0", stream_errs()); end
        n_cmp++; if (chain_errs() !== 0)  begin n_bad++; $display("FAIL discard_chain: %0d wrong stages, want 0", chain_errs()); end
        n_cmp++; if (rdy_late !== 0)      begin n_bad++; $display("FAIL discard_ready_after_last: got %0d cycles want 0", rdy_late); end
        n_cmp++; if (acc_cnt !== NW)      begin n_bad++; $display("FAIL discard_accepts: got %0d want %0d", acc_cnt, NW); end
    endtask

    task automatic test_reset_mid();
        int t;
        rand_words();
        clear_mon();
        @(posedge prog_clk); #1; start = 1'b1;
        @(posedge prog_clk); #1; start = 1'b0;
        s_valid = 1'b1; s_data = words[0];
        t = 0;
        do begin @(negedge prog_clk); #1; t++; end while (!s_ready && t < TMO);
        @(posedge prog_clk); #1;
        s_data = words[1];
        t = 0;
        do begin @(negedge prog_clk); #1; t++; end while (en_cnt < 40 && t < TMO);
        n_cmp++; if (en_cnt !== 40) begin n_bad++; $display("FAIL rstmid_reach40: got %0d want 40", en_cnt); end
        prog_rst = 1'b1;
        @(posedge prog_clk); #1;
        prog_rst = 1'b0; s_valid = 1'b0;
        n_cmp++; if (chain_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_chain_en: got %b want 0", chain_en); end
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        repeat (4) @(posedge prog_clk);
        #1;
        n_cmp++; if (done_cnt !== 0)   begin n_bad++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt); end
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle_ready: got %b want 0", s_ready); end
        rand_words();
        clear_mon();
        do_load(-1, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (en_cnt !== EN_LOAD)  begin n_bad++; $display("FAIL rstmid_reload_en: got %0d want %0d", en_cnt, EN_LOAD); end
        n_cmp++; if (chain_errs() !== 0)  begin n_bad++; $display("FAIL rstmid_reload_chain: %0d wrong stages, want 0", chain_errs()); end
        n_cmp++; if (done_cnt !== 1)      begin n_bad++; $display("FAIL rstmid_reload_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_start_ignored();
        rand_words();
        clear_mon();
        do_load(-1, 0, 1'b0, 1'b1, 1'b1);
        n_cmp++; if (done_cnt !== 1)      begin n_bad++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL ign_busy_after: got %b want 0", busy); end
        n_cmp++; if (s_ready !== 1'b0)    begin n_bad++; $display("FAIL ign_ready_after: got %b want 0", s_ready); end
        n_cmp++; if (stream_errs() !== 0) begin n_bad++; $display("FAIL ign_stream: %0d wrong bits, want 0", stream_errs()); end
        rand_words();
        clear_mon();
        do_load(-1, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (stream_errs() !== 0) begin n_bad++; $display("FAIL ign_next_stream: %0d wrong bits, want 0", stream_errs()); end
        n_cmp++; if (done_cnt !== 1)      begin n_bad++; $display("FAIL ign_next_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        int sidx, scyc;
        for (int it = 0; it < 4; it++) begin
            rand_words();
            sidx = $urandom_range(1, NW - 1);
            scyc = $urandom_range(0, 7);
            clear_mon();
            do_load(sidx, scyc, it[0], 1'b0, 1'b0);
            n_cmp++; if (en_cnt !== EN_LOAD) begin n_bad++; $display("FAIL rnd%0d_en_cnt: got %0d want %0d", it, en_cnt, EN_LOAD); end
            n_cmp++; if (last_en - first_en + 1 - en_cnt !== scyc) begin
                n_bad++; $display("FAIL rnd%0d_gaps: got %0d want %0d", it, last_en - first_en + 1 - en_cnt, scyc); end
            n_cmp++; if (stream_errs() !== 0) begin n_bad++; $display("FAIL rnd%0d_stream: %0d wrong bits, want 0", it, stream_errs()); end
            n_cmp++; if (chain_errs() !== 0)  begin n_bad++; $display("FAIL rnd%0d_chain: %0d wrong stages, want 0", it, chain_errs()); end
            n_cmp++; if (done_cnt !== 1)      begin n_bad++; $display("FAIL rnd%0d_done: got %0d want 1", it, done_cnt); end
            n_cmp++; if (rdy_late !== 0)      begin n_bad++; $display("FAIL rnd%0d_ready_late: got %0d want 0", it, rdy_late); end
        end
    endtask

    task automatic test_readback();
        words[0] = 32'h89ABCDEF; words[1] = 32'h01234567; words[2] = 32'h0000BEEF;
        clear_mon();
        stuck_en = 1'b0;
        do_load(-1, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (err_at_done !== 1'b0) begin n_bad++; $display("FAIL rb_good_error: got %b want 0", err_at_done); end
        n_cmp++; if (en_cnt !== EN_LOAD)   begin n_bad++; $display("FAIL rb_good_en_cnt: got %0d want %0d", en_cnt, EN_LOAD); end
        clear_mon();
        stuck_en = 1'b1;
        do_load(-1, 0, 1'b0, 1'b0, 1'b0);
        stuck_en = 1'b0;
`ifdef CFG_READBACK_EN
        n_cmp++; if (err_at_done !== 1'b1) begin n_bad++; $display("FAIL rb_stuck_error: got %b want 1", err_at_done); end
        n_cmp++; if (error !== 1'b1)       begin n_bad++; $display("FAIL rb_error_sticky: got %b want 1", error); end
`else
        n_cmp++; if (err_at_done !== 1'b0) begin n_bad++; $display("FAIL rb_off_error: got %b want 0", err_at_done); end
        n_cmp++; if (error !== 1'b0)       begin n_bad++; $display("FAIL rb_off_error_after: got %b want 0", error); end
`endif
        clear_mon();
        do_load(-1, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (err_at_done !== 1'b0) begin n_bad++; $display("FAIL rb_error_cleared: got %b want 0", err_at_done); end
        n_cmp++; if (chain_errs() !== 0)   begin n_bad++; $display("FAIL rb_chain: %0d wrong stages, want 0", chain_errs()); end
    endtask

    initial begin
        test_reset();
        test_contiguous();
        test_stall();
        test_upper_discard();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        test_readback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, want finished");
        $fatal(1, "timeout");
    end
endmodule
